// File: rtl/sc_hit_scorer.sv
// -----------------------------------------------------------------------------
// sc_hit_scorer
//
// Scoring stage behind the note matcher. Per-lane hit pulses are parked in a
// 37-slot pending buffer (scheduled time + song time at the hit). A round-robin
// arbiter feeds one hit at a time through a three-state FSM:
// IDLE (grant/latch) -> CALC (timing error, grade) -> APPLY (score update).
// The result is one graded hit every three cycles.
//
// Ports:
//   clk            system clock
//   reset          synchronous active-high reset
//   song_time      current song time (ms ticks)
//   match_trigger  one-cycle hit pulse per lane
//   match_time     per-lane scheduled time, lane i = bits [TW*i +: TW]
//   clear_score    zero score/combo/multiplier (pending hits and overflow kept)
//   score          saturating score accumulator
//   combo          consecutive non-MISS hits, saturating at 1023
//   multiplier     1..4, derived from combo
//   hit_valid      one-cycle pulse per graded hit
//   hit_grade      0=MISS 1=GOOD 2=PERFECT (held until next graded hit)
//   hit_note       lane of the graded hit (held until next graded hit)
//   overflow       sticky: trigger arrived on a lane that was still pending
//
// Optional build macro SC_GRADE_COUNTERS_EN adds saturating 16-bit
// perfect_cnt / good_cnt / miss_cnt outputs, zeroed by reset and clear_score.
// -----------------------------------------------------------------------------
module sc_hit_scorer #(
    parameter int NOTES       = 37,
    parameter int TW          = 16,
    parameter int PERFECT_WIN = 50,
    parameter int GOOD_WIN    = 150,
    parameter int PTS_PERFECT = 100,
    parameter int PTS_GOOD    = 50,
    parameter int SCORE_W     = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [TW-1:0]         song_time,
    input  logic [NOTES-1:0]      match_trigger,
    input  logic [NOTES*TW-1:0]   match_time,
    input  logic                  clear_score,
    output logic [SCORE_W-1:0]    score,
    output logic [9:0]            combo,
    output logic [2:0]            multiplier,
    output logic                  hit_valid,
    output logic [1:0]            hit_grade,
    output logic [5:0]            hit_note,
    output logic                  overflow
`ifdef SC_GRADE_COUNTERS_EN
    ,
    output logic [15:0]           perfect_cnt,
    output logic [15:0]           good_cnt,
    output logic [15:0]           miss_cnt
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;

    localparam logic [1:0] GR_MISS    = 2'd0;
    localparam logic [1:0] GR_GOOD    = 2'd1;
    localparam logic [1:0] GR_PERFECT = 2'd2;

    localparam logic [5:0]         LAST_LANE   = 6'(NOTES - 1);
    localparam logic [TW-1:0]      PERFECT_LIM = TW'(PERFECT_WIN);
    localparam logic [TW-1:0]      GOOD_LIM    = TW'(GOOD_WIN);
    localparam logic [SCORE_W:0]   PTS_P_EXT   = (SCORE_W+1)'(PTS_PERFECT);
    localparam logic [SCORE_W:0]   PTS_G_EXT   = (SCORE_W+1)'(PTS_GOOD);
    localparam logic [SCORE_W-1:0] SCORE_MAX   = {SCORE_W{1'b1}};
    localparam logic [9:0]         COMBO_MAX   = 10'd1023;

    // Multiplier as a function of the post-update combo: 1 + combo/10, capped at 4.
    function automatic logic [2:0] mult_of(input logic [9:0] c);
        logic [2:0] m;
        if (c >= 10'd30) begin
            m = 3'd4;
        end else if (c >= 10'd20) begin
            m = 3'd3;
        end else if (c >= 10'd10) begin
            m = 3'd2;
        end else begin
            m = 3'd1;
        end
        return m;
    endfunction

    // Pending buffer
    logic [NOTES-1:0] pending_q, pending_d;
    logic [TW-1:0]    note_t_q [NOTES];
    logic [TW-1:0]    note_t_d [NOTES];
    logic [TW-1:0]    hit_t_q  [NOTES];
    logic [TW-1:0]    hit_t_d  [NOTES];
    logic             overflow_q, overflow_d;

    // Arbiter
    logic [5:0] rr_ptr_q, rr_ptr_d;
    logic       grant_found_s;
    logic [5:0] grant_idx_s;
    logic       grant_take_s;

    // FSM and in-flight hit
    logic [1:0]    state_q, state_d;
    logic [5:0]    cur_note_q, cur_note_d;
    logic [TW-1:0] cur_note_t_q, cur_note_t_d;
    logic [TW-1:0] cur_hit_t_q, cur_hit_t_d;
    logic [1:0]    grade_q, grade_d;
    logic [TW-1:0] diff_s, abs_s;

    // Score path
    logic [SCORE_W:0]   pts_s, add_s, sum_s;
    logic [SCORE_W-1:0] score_sat_s;
    logic [9:0]         combo_inc_s;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [9:0]         combo_q, combo_d;
    logic [2:0]         mult_q, mult_d;
    logic               hit_valid_q, hit_valid_d;
    logic [1:0]         hit_grade_q, hit_grade_d;
    logic [5:0]         hit_note_q, hit_note_d;

    // Round-robin search: first pending lane at or after rr_ptr, wrapping.
    always_comb begin
        logic [6:0] idx_v;
        idx_v         = 7'd0;
        grant_found_s = 1'b0;
        grant_idx_s   = 6'd0;
        for (int k = 0; k < NOTES; k++) begin
            idx_v = {1'b0, rr_ptr_q} + 7'(k);
            idx_v = (idx_v >= 7'(NOTES)) ? (idx_v - 7'(NOTES)) : idx_v;
            if (!grant_found_s && pending_q[idx_v[5:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = idx_v[5:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    assign grant_take_s = (state_q == ST_IDLE) && grant_found_s;
    assign rr_ptr_d     = grant_take_s ? ((grant_idx_s == LAST_LANE) ? 6'd0 : grant_idx_s + 6'd1)
                                       : rr_ptr_q;

    // Capture new triggers into the pending buffer; the lane granted this
    // cycle is already free, so a fresh trigger on it is accepted.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        note_t_d   = note_t_q;
        hit_t_d    = hit_t_q;
        if (grant_take_s) begin
            pending_d[grant_idx_s] = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        for (int i = 0; i < NOTES; i++) begin
            if (match_trigger[i]) begin
                if (pending_d[i]) begin
                    overflow_d = 1'b1;
                end else begin
                    pending_d[i] = 1'b1;
                    note_t_d[i]  = match_time[TW*i +: TW];
                    hit_t_d[i]   = song_time;
                end
            end else begin
                overflow_d = overflow_d;
            end
        end
    end

    // Timing error: signed modulo-2^TW difference folded to a magnitude.
    assign diff_s = cur_hit_t_q - cur_note_t_q;
    assign abs_s  = diff_s[TW-1] ? (-diff_s) : diff_s;

    // Score arithmetic uses the multiplier in force before this hit.
    assign pts_s       = (grade_q == GR_PERFECT) ? PTS_P_EXT : PTS_G_EXT;
    assign add_s       = pts_s * (SCORE_W+1)'(mult_q);
    assign sum_s       = {1'b0, score_q} + add_s;
    assign score_sat_s = sum_s[SCORE_W] ? SCORE_MAX : sum_s[SCORE_W-1:0];
    assign combo_inc_s = (combo_q == COMBO_MAX) ? COMBO_MAX : (combo_q + 10'd1);

    // FSM next state, grading and score/combo update; clear_score wins last.
    always_comb begin
        state_d      = state_q;
        cur_note_d   = cur_note_q;
        cur_note_t_d = cur_note_t_q;
        cur_hit_t_d  = cur_hit_t_q;
        grade_d      = grade_q;
        score_d      = score_q;
        combo_d      = combo_q;
        mult_d       = mult_q;
        hit_valid_d  = 1'b0;
        hit_grade_d  = hit_grade_q;
        hit_note_d   = hit_note_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_take_s) begin
                    cur_note_d   = grant_idx_s;
                    cur_note_t_d = note_t_q[grant_idx_s];
                    cur_hit_t_d  = hit_t_q[grant_idx_s];
                    state_d      = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (abs_s <= PERFECT_LIM) begin
                    grade_d = GR_PERFECT;
                end else if (abs_s <= GOOD_LIM) begin
                    grade_d = GR_GOOD;
                end else begin
                    grade_d = GR_MISS;
                end
                state_d = ST_APPLY;
            end
            ST_APPLY: begin
                hit_valid_d = 1'b1;
                hit_grade_d = grade_q;
                hit_note_d  = cur_note_q;
                if (grade_q == GR_MISS) begin
                    combo_d = 10'd0;
                end else begin
                    score_d = score_sat_s;
                    combo_d = combo_inc_s;
                end
                mult_d  = mult_of(combo_d);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (clear_score) begin
            score_d = {SCORE_W{1'b0}};
            combo_d = 10'd0;
            mult_d  = 3'd1;
        end else begin
            score_d = score_d;
        end
    end

    // Control state, pending flags and outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= {NOTES{1'b0}};
            overflow_q  <= 1'b0;
            rr_ptr_q    <= 6'd0;
            state_q     <= ST_IDLE;
            cur_note_q  <= 6'd0;
            grade_q     <= GR_MISS;
            score_q     <= {SCORE_W{1'b0}};
            combo_q     <= 10'd0;
            mult_q      <= 3'd1;
            hit_valid_q <= 1'b0;
            hit_grade_q <= GR_MISS;
            hit_note_q  <= 6'd0;
        end else begin
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= state_d;
            cur_note_q  <= cur_note_d;
            grade_q     <= grade_d;
            score_q     <= score_d;
            combo_q     <= combo_d;
            mult_q      <= mult_d;
            hit_valid_q <= hit_valid_d;
            hit_grade_q <= hit_grade_d;
            hit_note_q  <= hit_note_d;
        end
    end

    // Slot payloads; only read while their pending flag or the FSM says so.
    always_ff @(posedge clk) begin
        note_t_q     <= note_t_d;
        hit_t_q      <= hit_t_d;
        cur_note_t_q <= cur_note_t_d;
        cur_hit_t_q  <= cur_hit_t_d;
    end

    assign score      = score_q;
    assign combo      = combo_q;
    assign multiplier = mult_q;
    assign hit_valid  = hit_valid_q;
    assign hit_grade  = hit_grade_q;
    assign hit_note   = hit_note_q;
    assign overflow   = overflow_q;

`ifdef SC_GRADE_COUNTERS_EN
    logic [15:0] perfect_cnt_q, perfect_cnt_d;
    logic [15:0] good_cnt_q, good_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    // Per-grade tallies, bumped in APPLY and zeroed by clear_score.
    always_comb begin
        perfect_cnt_d = perfect_cnt_q;
        good_cnt_d    = good_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        if (clear_score) begin
            perfect_cnt_d = 16'd0;
            good_cnt_d    = 16'd0;
            miss_cnt_d    = 16'd0;
        end else if (state_q == ST_APPLY) begin
            case (grade_q)
                GR_PERFECT: perfect_cnt_d = sat_inc16(perfect_cnt_q);
                GR_GOOD:    good_cnt_d    = sat_inc16(good_cnt_q);
                default:    miss_cnt_d    = sat_inc16(miss_cnt_q);
            endcase
        end else begin
            perfect_cnt_d = perfect_cnt_q;
        end
    end

    // Grade counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            perfect_cnt_q <= 16'd0;
            good_cnt_q    <= 16'd0;
            miss_cnt_q    <= 16'd0;
        end else begin
            perfect_cnt_q <= perfect_cnt_d;
            good_cnt_q    <= good_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    assign perfect_cnt = perfect_cnt_q;
    assign good_cnt    = good_cnt_q;
    assign miss_cnt    = miss_cnt_q;
`endif

endmodule

// File: tb/tb_sc_hit_scorer.sv
// Self-checking bench for sc_hit_scorer: a cycle-level transaction model
// (pending set, round-robin pick, fixed grant-to-result delay, score rules)
// is compared against every output each cycle, plus directed literal checks.
module tb_sc_hit_scorer;
    localparam int NOTES = 37;
    localparam int TW    = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [TW-1:0]         song_time;
    logic [NOTES-1:0]      match_trigger;
    logic [NOTES*TW-1:0]   match_time;
    logic                  clear_score;
    logic [23:0]           score;
    logic [9:0]            combo;
    logic [2:0]            multiplier;
    logic                  hit_valid;
    logic [1:0]            hit_grade;
    logic [5:0]            hit_note;
    logic                  overflow;

    always #5 clk = ~clk;

    sc_hit_scorer dut (
        .clk          (clk),
        .reset        (reset),
        .song_time    (song_time),
        .match_trigger(match_trigger),
        .match_time   (match_time),
        .clear_score  (clear_score),
        .score        (score),
        .combo        (combo),
        .multiplier   (multiplier),
        .hit_valid    (hit_valid),
        .hit_grade    (hit_grade),
        .hit_note     (hit_note),
        .overflow     (overflow)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- model state ----------------
    bit m_pend [NOTES];
    int m_note [NOTES];
    int m_hit  [NOTES];
    int m_rr, m_next_free, m_cyc;
    bit m_infl;
    int m_infl_due, m_infl_lane, m_infl_grade;
    int m_score, m_combo, m_mult, m_grade, m_lane;
    bit m_valid, m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Grade from the signed modulo-65536 timing error.
    function automatic int grade_of(input int note, input int hit);
        int e;
        e = (hit - note) & 32'h0000FFFF;
        if (e >= 32768) e = 65536 - e;
        if (e <= 50)  return 2;
        if (e <= 150) return 1;
        return 0;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int g;
        if (reset) begin
            for (int i = 0; i < NOTES; i++) m_pend[i] = 1'b0;
            m_rr = 0; m_infl = 1'b0; m_next_free = m_cyc + 1;
            m_score = 0; m_combo = 0; m_mult = 1;
            m_valid = 1'b0; m_grade = 0; m_lane = 0; m_ovf = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (m_infl && m_infl_due == m_cyc) begin
                m_infl = 1'b0; m_valid = 1'b1;
                m_grade = m_infl_grade; m_lane = m_infl_lane;
                if (m_grade != 0) begin
                    m_score = m_score + ((m_grade == 2) ? 100 : 50) * m_mult;
                    if (m_score > 24'hFFFFFF) m_score = 24'hFFFFFF;
                    m_combo = (m_combo < 1023) ? m_combo + 1 : 1023;
                end else begin
                    m_combo = 0;
                end
                m_mult = 1 + m_combo / 10;
                if (m_mult > 4) m_mult = 4;
            end
            if (clear_score) begin
                m_score = 0; m_combo = 0; m_mult = 1;
            end
            g = -1;
            if (m_cyc >= m_next_free) begin
                for (int k = 0; k < NOTES; k++)
                    if (g < 0 && m_pend[(m_rr + k) % NOTES]) g = (m_rr + k) % NOTES;
            end
            if (g >= 0) begin
                m_pend[g] = 1'b0;
                m_rr = (g + 1) % NOTES;
                m_infl = 1'b1; m_infl_due = m_cyc + 2; m_infl_lane = g;
                m_infl_grade = grade_of(m_note[g], m_hit[g]);
                m_next_free = m_cyc + 3;
            end
            for (int i = 0; i < NOTES; i++) begin
                if (match_trigger[i]) begin
                    if (m_pend[i]) m_ovf = 1'b1;
                    else begin
                        m_pend[i] = 1'b1;
                        m_note[i] = int'(match_time[TW*i +: TW]);
                        m_hit[i]  = int'(song_time);
                    end
                end
            end
        end
        m_cyc++;
    endtask

    task automatic compare_outputs();
        chk($sformatf("c%0d_hit_valid", m_cyc), hit_valid, m_valid);
        chk($sformatf("c%0d_hit_grade", m_cyc), hit_grade, m_grade);
        chk($sformatf("c%0d_hit_note", m_cyc), hit_note, m_lane);
        chk($sformatf("c%0d_score", m_cyc), score, m_score);
        chk($sformatf("c%0d_combo", m_cyc), combo, m_combo);
        chk($sformatf("c%0d_multiplier", m_cyc), multiplier, m_mult);
        chk($sformatf("c%0d_overflow", m_cyc), overflow, m_ovf);
    endtask

    // One clock: model, edge, sample at negedge, release pulse inputs.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
        match_trigger = '0;
        clear_score   = 1'b0;
    endtask

    task automatic wait_valid(input int max_cyc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (hit_valid !== 1'b1 && n < max_cyc);
        if (hit_valid !== 1'b1) begin
            checks++; failures++;
            $display("FAIL wait_valid: no hit_valid within %0d cycles", max_cyc);
        end
    endtask

    task automatic hit(input int lane, input int note, input int t);
        song_time = TW'(t);
        match_time[TW*lane +: TW] = TW'(note);
        match_trigger[lane] = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct { int note; int t; int grade; } bnd_t;
    bnd_t bnd [8];

    initial begin
        int n;
        reset = 1'b1; song_time = '0; match_trigger = '0; match_time = '0; clear_score = 1'b0;
        m_cyc = 0;
        do_reset();
        chk("rst_score", score, 0);
        chk("rst_multiplier", multiplier, 1);
        chk("rst_hit_valid", hit_valid, 0);

        // Single PERFECT hit on lane 3, latency 3 cycles after capture.
        hit(3, 1000, 1020);
        tick();
        wait_valid(10, n);
        chk("t1_latency", n, 3);
        chk("t1_grade", hit_grade, 2);
        chk("t1_note", hit_note, 3);
        chk("t1_score", score, 100);
        chk("t1_combo", combo, 1);
        chk("t1_mult", multiplier, 1);

        // Chord on lanes 0, 5, 36 after reset: served 0, 5, 36, 3 cycles apart.
        do_reset();
        hit(0, 500, 500); hit(5, 500, 500); hit(36, 500, 500);
        tick();
        wait_valid(10, n); chk("t2_lat0", n, 3); chk("t2_note0", hit_note, 0);
        wait_valid(10, n); chk("t2_gap1", n, 3); chk("t2_note1", hit_note, 5);
        wait_valid(10, n); chk("t2_gap2", n, 3); chk("t2_note2", hit_note, 36);
        chk("t2_score", score, 300);

        // Ten PERFECT hits, then a GOOD at multiplier 2.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            hit(2, 1000, 1000);
            tick();
            wait_valid(10, n);
        end
        chk("t3_combo10", combo, 10);
        chk("t3_mult10", multiplier, 2);
        chk("t3_score10", score, 1000);
        hit(2, 1000, 1100);
        tick();
        wait_valid(10, n);
        chk("t3_good_grade", hit_grade, 1);
        chk("t3_good_score", score, 1100);

        // One more PERFECT (combo 12), then an error of 151 -> MISS.
        hit(2, 1000, 1000); tick(); wait_valid(10, n);
        chk("t4_combo12", combo, 12);
        chk("t4_score", score, 1300);
        hit(2, 1000, 1151); tick(); wait_valid(10, n);
        chk("t4_miss_grade", hit_grade, 0);
        chk("t4_miss_combo", combo, 0);
        chk("t4_miss_mult", multiplier, 1);
        chk("t4_miss_score", score, 1300);

        // Grade window boundaries, both signs, and the wrap/half-range cases.
        bnd[0] = '{1000, 1050, 2};  bnd[1] = '{1000, 1051, 1};
        bnd[2] = '{1000, 950, 2};   bnd[3] = '{1000, 1150, 1};
        bnd[4] = '{1000, 850, 1};   bnd[5] = '{1000, 849, 0};
        bnd[6] = '{32768, 0, 0};    bnd[7] = '{65520, 5, 2};
        for (int k = 0; k < 8; k++) begin
            hit(20, bnd[k].note, bnd[k].t);
            tick();
            wait_valid(10, n);
            chk($sformatf("t5_bnd%0d_grade", k), hit_grade, bnd[k].grade);
        end

        // Wrapped PERFECT on lane 10 plus a re-trigger while still pending.
        do_reset();
        hit(9, 5, 5); hit(10, 65520, 5);
        tick();
        hit(10, 0, 5000);
        tick();
        chk("t6_overflow", overflow, 1);
        wait_valid(10, n); chk("t6_first_note", hit_note, 9);
        wait_valid(10, n); chk("t6_second_note", hit_note, 10);
        chk("t6_second_grade", hit_grade, 2);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (hit_valid === 1'b1) n++;
        end
        chk("t6_extra_hits", n, 0);
        chk("t6_score", score, 200);

        // clear_score in the APPLY cycle of a PERFECT hit.
        hit(1, 300, 300);
        tick();
        tick();
        tick();
        clear_score = 1'b1;
        tick();
        chk("t7_valid", hit_valid, 1);
        chk("t7_grade", hit_grade, 2);
        chk("t7_score", score, 0);
        chk("t7_combo", combo, 0);
        chk("t7_overflow_kept", overflow, 1);

        // Reset while a hit is in flight discards it.
        hit(4, 100, 100);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (hit_valid === 1'b1) n++;
        end
        chk("t8_discarded", n, 0);
        chk("t8_overflow_cleared", overflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sc_hit_scorer.md
Name: sc_hit_scorer

Overview:
- Scoring stage directly downstream of the note-matching stage.
- Consumes the 37 per-note `match_trigger` pulses and their 16-bit `match_time` values. Serializes simultaneous hits through a round-robin pending buffer.
- Grades each hit by timing error against the song time captured at the hit, then accumulates score, combo and multiplier for the display/UI stage.

Parameters:
- NOTES, 37, number of note lanes.
- TW, 16, time width in ms ticks; matches `song_time`.
- PERFECT_WIN, 50, max |error| graded PERFECT.
- GOOD_WIN, 150, max |error| graded GOOD.
- PTS_PERFECT, 100, base points for PERFECT.
- PTS_GOOD, 50, base points for GOOD.
- SCORE_W, 24, score accumulator width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- song_time  in  TW  current song time.
- match_trigger  in  NOTES  one-cycle hit pulse per note.
- match_time  in  NOTES*TW  per-note scheduled time; lane i is bits [TW*i+TW-1:TW*i].
- clear_score  in  1  zero score/combo (new song).
- score  out  SCORE_W  accumulated score.
- combo  out  10  consecutive non-MISS hits.
- multiplier  out  3  current multiplier, 1..4.
- hit_valid  out  1  one-cycle pulse per graded hit.
- hit_grade  out  2  0=MISS, 1=GOOD, 2=PERFECT; valid with `hit_valid`.
- hit_note  out  6  lane index of the graded hit.
- overflow  out  1  sticky: a trigger arrived on a lane already pending.

Behaviour:
- Reset values: score=0, combo=0, multiplier=1, hit_valid=0, hit_grade=0, hit_note=0, overflow=0. Reset also clears all pending bits, the FSM (to IDLE) and the round-robin pointer (to 0). Reset mid-hit discards the in-flight hit.
- Capture (every cycle): for each lane i with match_trigger[i]=1:
  - pending[i]<=1, note_t[i]<=match_time lane i, hit_t[i]<=song_time.
  - If pending[i] is already 1: keep the old slot contents, drop the new trigger, set overflow.
  - Capture set beats arbiter clear on the same lane in the same cycle.
- Arbiter: picks the lowest pending index >= rr_ptr, wrapping to 0. On grant, rr_ptr<=grant+1 (wraps 36->0).
- FSM:
  - IDLE: if any pending, grant lane g, clear pending[g], latch g and its slot -> CALC. Else stay.
  - CALC: diff = hit_t - note_t (mod 2^TW). abs = diff[TW-1] ? -diff : diff. Grade: abs<=PERFECT_WIN -> PERFECT; abs<=GOOD_WIN -> GOOD; else MISS. Register abs and grade -> APPLY.
  - APPLY: pulse hit_valid; drive hit_grade and hit_note (hold until the next APPLY).
    - PERFECT/GOOD: score += pts*multiplier, using the pre-update multiplier; saturate at 2^SCORE_W-1. combo += 1, saturating at 1023.
    - MISS: combo<=0.
    - multiplier<=min(1+combo_new/10, 4).
    - -> IDLE.
- Latency: an isolated trigger at edge T gives hit_valid high in the cycle after edge T+3, i.e. 3 cycles after capture. Throughput is one hit per 3 cycles; the 37-slot buffer absorbs chords.
- Wrap-around: time difference is signed modulo 2^TW, so a hit at 0x0005 vs note 0xFFF0 has error 21.
- clear_score:
  - Sets score=0, combo=0, multiplier=1 and takes priority over an APPLY update in the same cycle.
  - hit_valid/grade still pulse in that cycle.
  - Does not flush pending hits or clear overflow.

Optional Feature:
- Macro: SC_GRADE_COUNTERS_EN.
- Defined: adds outputs perfect_cnt, good_cnt, miss_cnt (16 bits each, saturating). Each increments in APPLY per grade; zeroed by reset and clear_score.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then trigger lane 3 with match_time=1000 at song_time=1020 -> hit_valid 3 cycles later, grade=2, hit_note=3, score=100, combo=1, multiplier=1.
- Triggers on lanes 0, 5 and 36 in the same cycle, all error 0 -> three hit_valid pulses 3 cycles apart, order 0, 5, 36; score=300.
- 10 consecutive PERFECT hits, then 1 GOOD -> after the 10th, combo=10 and multiplier=2; the GOOD adds 50*2 (score 1100).
- Hit with error 151 after combo=12 -> grade=0, combo=0, multiplier=1, score unchanged.
- Note 0xFFF0, hit at song_time 0x0005 -> grade PERFECT (error 21). Second trigger on the same lane while it is still pending -> overflow=1, only one hit graded.
- clear_score asserted in the APPLY cycle of a PERFECT hit -> hit_valid=1, grade=2, but score=0 and combo=0 next cycle.
